// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared types and defaults for the async SRAM controller.
// Holds the FSM state enum, the operation-type encoding, default bus widths
// and small helpers used by ram_controller and ram_data_iobuf.
package ram_ctrl_pkg;

  localparam int RAM_ADDR_W      = 18;
  localparam int RAM_DATA_W      = 16;
  localparam int RAM_WAIT_CYCLES = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_SETUP = 3'd1,
    W_PULSE = 3'd2,
    W_HOLD  = 3'd3,
    R_SETUP = 3'd4,
    R_WAIT  = 3'd5,
    DONE    = 3'd6
  } ram_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } ram_op_t;

  // The data bus is driven while the FSM sits in any write state. Because the
  // enable is registered, this returns the value it must take after the edge.
  function automatic logic bus_drive_next(ram_state_t cur, logic accept_wr);
    return accept_wr || (cur == W_SETUP) || (cur == W_PULSE);
  endfunction

  // Width of the wait-state down-counter; never narrower than one bit.
  function automatic int wait_cnt_width(int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ram_data_iobuf.sv
// ram_data_iobuf: registered tristate driver for the SRAM data bus.
// The drive enable and the write word are both flops, so the pin driver
// switches cleanly on the clock edge together with the SRAM strobes.
module ram_data_iobuf
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drive_nxt,
  input  logic              load,
  input  logic [DATA_W-1:0] wdata_in,
  inout  wire  [DATA_W-1:0] data
);

  logic              drive_q;
  logic [DATA_W-1:0] wdata_q;

  // Register the drive enable every cycle; capture write data only on accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      drive_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      drive_q <= drive_nxt;
      if (load) begin
        wdata_q <= wdata_in;
      end
    end
  end

  assign data = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: rtl/ram_controller.sv
// ram_controller: registered single-port controller for an external async SRAM.
// Turns a level request (en with we/re) into chip-enable / output-enable /
// write-enable strobe timing, latches read data and reports completion on done.
// Optional macro RAM_CTRL_WAIT_STATES_EN stretches W_PULSE and R_WAIT by
// WAIT_CYCLES cycles using an internal down-counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | strobes inactive, waiting for en & (we | re)
// W_SETUP | chip enabled, write data on the bus, ram_we still high
// W_PULSE | ram_we low (1 cycle, or 1+WAIT_CYCLES with wait states)
// W_HOLD  | ram_we released, data held on the bus
// R_SETUP | chip and output enable low, SRAM drives the bus
// R_WAIT  | strobes held; read word captured when leaving
// DONE    | done high until en or the recorded strobe drops
module ram_controller
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = RAM_ADDR_W,
  parameter int DATA_W      = RAM_DATA_W,
  parameter int WAIT_CYCLES = RAM_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              re,
  input  logic              we,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              ram_en,
  output logic              ram_oe,
  output logic              ram_we,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  inout  wire  [DATA_W-1:0] data
);

  ram_state_t state;
  ram_op_t    op_type;
  logic       accept_wr;
  logic       accept_rd;
  logic       drive_nxt;
  logic       strobe_dropped;
  logic       wait_tc;

`ifdef RAM_CTRL_WAIT_STATES_EN
  localparam int                CNT_W     = wait_cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(WAIT_CYCLES);
  logic [CNT_W-1:0] wait_cnt;

  // Terminal count of the stretch timer ends W_PULSE / R_WAIT.
  always_comb begin
    wait_tc = (wait_cnt == '0);
  end
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;

  // Without wait states the pulse/wait phases always last exactly one cycle.
  always_comb begin
    wait_tc = 1'b1;
  end
`endif

  // Request decode in IDLE (write wins) and the DONE release condition.
  always_comb begin
    accept_wr      = (state == IDLE) && en && we;
    accept_rd      = (state == IDLE) && en && re && !we;
    strobe_dropped = (op_type == OP_WR) ? !we : !re;
    drive_nxt      = bus_drive_next(state, accept_wr);
  end

  ram_data_iobuf #(
    .DATA_W(DATA_W)
  ) u_iobuf (
    .clk      (clk),
    .rst      (rst),
    .drive_nxt(drive_nxt),
    .load     (accept_wr),
    .wdata_in (data_in),
    .data     (data)
  );

  // Sequencing FSM; every SRAM strobe, done, addr and data_out is a flop here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      op_type  <= OP_RD;
      ram_en   <= 1'b1;
      ram_oe   <= 1'b1;
      ram_we   <= 1'b1;
      done     <= 1'b0;
      addr     <= '0;
      data_out <= '0;
`ifdef RAM_CTRL_WAIT_STATES_EN
      wait_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept_wr) begin
            addr    <= addr_in;
            op_type <= OP_WR;
            ram_en  <= 1'b0;
            ram_oe  <= 1'b1;
            ram_we  <= 1'b1;
            state   <= W_SETUP;
          end else if (accept_rd) begin
            addr    <= addr_in;
            op_type <= OP_RD;
            ram_en  <= 1'b0;
            ram_oe  <= 1'b0;
            ram_we  <= 1'b1;
            state   <= R_SETUP;
          end
        end

        W_SETUP: begin
          ram_we <= 1'b0;
          state  <= W_PULSE;
`ifdef RAM_CTRL_WAIT_STATES_EN
          wait_cnt <= WAIT_LOAD;
`endif
        end

        W_PULSE: begin
          if (wait_tc) begin
            ram_we <= 1'b1;
            state  <= W_HOLD;
          end
`ifdef RAM_CTRL_WAIT_STATES_EN
          else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
`endif
        end

        W_HOLD: begin
          ram_en <= 1'b1;
          done   <= 1'b1;
          state  <= DONE;
        end

        R_SETUP: begin
          state <= R_WAIT;
`ifdef RAM_CTRL_WAIT_STATES_EN
          wait_cnt <= WAIT_LOAD;
`endif
        end

        R_WAIT: begin
          if (wait_tc) begin
            data_out <= data;
            ram_oe   <= 1'b1;
            ram_en   <= 1'b1;
            done     <= 1'b1;
            state    <= DONE;
          end
`ifdef RAM_CTRL_WAIT_STATES_EN
          else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
`endif
        end

        DONE: begin
          if (!en || strobe_dropped) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          ram_en <= 1'b1;
          ram_oe <= 1'b1;
          ram_we <= 1'b1;
          done   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_controller.sv
// tb_ram_controller: directed, table-driven bench for ram_controller with a
// small async SRAM model and a probe driver used to prove the bus is released.
module tb_ram_controller;

`ifdef RAM_CTRL_WAIT_STATES_EN
  localparam int WX = 2;
`else
  localparam int WX = 0;
`endif
  localparam logic [15:0] PROBE = 16'h5A50;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, re = 1'b0, we = 1'b0;
  logic [15:0] data_in = '0;
  logic [17:0] addr_in = '0;
  logic        ram_en, ram_oe, ram_we, done;
  logic [17:0] addr;
  logic [15:0] data_out;
  wire  [15:0] data_bus;

  logic        probe_en = 1'b0;
  logic [15:0] mem [0:15];
  int          n_checks = 0;
  int          n_errors = 0;
  int          overlap  = 0;

  always #5 clk = ~clk;

  ram_controller #(
    .ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .re(re), .we(we),
    .data_in(data_in), .addr_in(addr_in),
    .ram_en(ram_en), .ram_oe(ram_oe), .ram_we(ram_we), .done(done),
    .addr(addr), .data_out(data_out), .data(data_bus)
  );

  // SRAM model: drives on read, stores on the rising edge of ram_we.
  assign data_bus = probe_en ? PROBE :
                    (!ram_en && !ram_oe) ? mem[addr[3:0]] : 16'bz;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
  end

  always @(posedge ram_we) begin
    if (!ram_en) mem[addr[3:0]] <= data_bus;
  end

  always @(negedge clk) begin
    if (!ram_oe && !ram_we) overlap++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_z(input string nm);
    probe_en = 1'b1;
    #1;
    check(nm, {16'h0, data_bus}, {16'h0, PROBE});
    probe_en = 1'b0;
    #1;
  endtask

  typedef struct {
    logic        r, e, rd, wr;
    logic [17:0] a;
    logic [15:0] d;
    logic        x_en, x_oe, x_we, x_done;
    logic [17:0] x_addr;
    logic [15:0] x_dout;
    logic [1:0]  bus_chk;   // 0 skip, 1 expect x_bus driven, 2 expect released
    logic [15:0] x_bus;
  } vec_t;

  vec_t vec [0:18];

  // Runs one operation with the request held until done, then drops it.
  task automatic run_op(input logic is_wr, input logic [17:0] a, input logic [15:0] d,
                        output int strobe_lo, output int done_at);
    @(negedge clk);
    en = 1'b1; we = is_wr; re = !is_wr; addr_in = a; data_in = d;
    strobe_lo = 0;
    done_at   = -1;
    for (int c = 0; c < 20 && done_at < 0; c++) begin
      @(posedge clk); #1;
      if (is_wr ? !ram_we : !ram_oe) strobe_lo++;
      if (done) done_at = c;
    end
    @(negedge clk);
    en = 1'b0; we = 1'b0; re = 1'b0;
    @(posedge clk); #1;
  endtask

  int lo, dn;

  initial begin
    // Reset held two cycles
    rst = 1'b0; en = 1'b1; we = 1'b1; addr_in = 18'h3; data_in = 16'h9;
    @(posedge clk); @(posedge clk); #1;
    check("rst.ram_en", ram_en, 1);
    check("rst.ram_oe", ram_oe, 1);
    check("rst.ram_we", ram_we, 1);
    check("rst.done", done, 0);
    check("rst.addr", addr, 0);
    check("rst.data_out", data_out, 0);
    check_z("rst.bus_z");

    //          r  e  rd wr a       d         en oe we dn addr   dout     chk bus
    vec[0]  = '{1, 0, 0, 1, 18'h7, 16'h3,    1, 1, 1, 0, 18'h0, 16'h0,   2, 0};
    vec[1]  = '{1, 0, 1, 0, 18'h7, 16'h3,    1, 1, 1, 0, 18'h0, 16'h0,   2, 0};
    vec[2]  = '{1, 1, 0, 1, 18'h5, 16'hE,    0, 1, 1, 0, 18'h5, 16'h0,   1, 16'hE};
    vec[3]  = '{1, 1, 0, 1, 18'h9, 16'h77,   0, 1, 0, 0, 18'h5, 16'h0,   1, 16'hE};
    vec[4]  = '{1, 1, 0, 1, 18'h9, 16'h77,   0, 1, 1, 0, 18'h5, 16'h0,   1, 16'hE};
    vec[5]  = '{1, 1, 0, 1, 18'h9, 16'h77,   1, 1, 1, 1, 18'h5, 16'h0,   2, 0};
    vec[6]  = '{1, 1, 0, 1, 18'h9, 16'h77,   1, 1, 1, 1, 18'h5, 16'h0,   2, 0};
    vec[7]  = '{1, 1, 1, 0, 18'h5, 16'h0,    1, 1, 1, 0, 18'h5, 16'h0,   2, 0};
    vec[8]  = '{1, 1, 1, 0, 18'h5, 16'h0,    0, 0, 1, 0, 18'h5, 16'h0,   2, 0};
    vec[9]  = '{1, 1, 1, 0, 18'h5, 16'h0,    0, 0, 1, 0, 18'h5, 16'h0,   2, 0};
    vec[10] = '{1, 1, 1, 0, 18'h5, 16'h0,    1, 1, 1, 1, 18'h5, 16'hE,   2, 0};
    vec[11] = '{1, 1, 1, 0, 18'h5, 16'h0,    1, 1, 1, 1, 18'h5, 16'hE,   0, 0};
    vec[12] = '{1, 0, 1, 0, 18'h5, 16'h0,    1, 1, 1, 0, 18'h5, 16'hE,   0, 0};
    vec[13] = '{1, 1, 1, 1, 18'h3, 16'h1234, 0, 1, 1, 0, 18'h3, 16'hE,   1, 16'h1234};
    vec[14] = '{1, 1, 1, 1, 18'h3, 16'h1234, 0, 1, 0, 0, 18'h3, 16'hE,   1, 16'h1234};
    vec[15] = '{1, 1, 1, 1, 18'h3, 16'h1234, 0, 1, 1, 0, 18'h3, 16'hE,   1, 16'h1234};
    vec[16] = '{1, 1, 1, 1, 18'h3, 16'h1234, 1, 1, 1, 1, 18'h3, 16'hE,   2, 0};
    vec[17] = '{1, 0, 1, 1, 18'h3, 16'h1234, 1, 1, 1, 0, 18'h3, 16'hE,   2, 0};
    vec[18] = '{1, 0, 0, 0, 18'h3, 16'h1234, 1, 1, 1, 0, 18'h3, 16'hE,   2, 0};

`ifndef RAM_CTRL_WAIT_STATES_EN
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst = vec[i].r; en = vec[i].e; re = vec[i].rd; we = vec[i].wr;
      addr_in = vec[i].a; data_in = vec[i].d;
      @(posedge clk); #1;
      check($sformatf("v%0d.ram_en", i), ram_en, vec[i].x_en);
      check($sformatf("v%0d.ram_oe", i), ram_oe, vec[i].x_oe);
      check($sformatf("v%0d.ram_we", i), ram_we, vec[i].x_we);
      check($sformatf("v%0d.done", i), done, vec[i].x_done);
      check($sformatf("v%0d.addr", i), addr, vec[i].x_addr);
      check($sformatf("v%0d.data_out", i), data_out, vec[i].x_dout);
      if (vec[i].bus_chk == 2'd1)
        check($sformatf("v%0d.bus", i), data_bus, vec[i].x_bus);
      else if (vec[i].bus_chk == 2'd2)
        check_z($sformatf("v%0d.bus_z", i));
    end
    check("mem5", mem[5], 16'hE);
    check("mem3", mem[3], 16'h1234);
`else
    @(negedge clk);
    rst = 1'b1; en = 1'b0; we = 1'b0; re = 1'b0;
`endif

    // Write/read latency and strobe width, including wait states if built in
    run_op(1'b1, 18'hA, 16'hBEEF, lo, dn);
    check("wr.we_low_cycles", lo, 1 + WX);
    check("wr.done_latency", dn, 3 + WX);
    check("wr.done_cleared", done, 0);
    check("wr.mem", mem[10], 16'hBEEF);
    run_op(1'b0, 18'hA, 16'h0, lo, dn);
    check("rd.oe_low_cycles", lo, 2 + WX);
    check("rd.done_latency", dn, 2 + WX);
    check("rd.data_out", data_out, 16'hBEEF);
    check("rd.done_cleared", done, 0);

    // Reset during W_PULSE aborts the write at once
    @(negedge clk);
    en = 1'b1; we = 1'b1; addr_in = 18'h9; data_in = 16'h00F0;
    @(posedge clk); @(posedge clk); #1;
    check("abort.in_pulse", ram_we, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort.ram_we", ram_we, 1);
    check("abort.ram_en", ram_en, 1);
    check("abort.done", done, 0);
    check("abort.addr", addr, 0);
    check_z("abort.bus_z");
    @(negedge clk);
    rst = 1'b1; we = 1'b0; re = 1'b1; addr_in = 18'hA;
    @(posedge clk); #1;
    check("abort.idle_accepts_read", ram_oe, 0);
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk); #1;
    end
    check("abort.read_done", done, 1);
    check("abort.read_data", data_out, 16'hBEEF);
    @(negedge clk);
    en = 1'b0; re = 1'b0;
    @(posedge clk); #1;

    check("oe_we_overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
